// File: rtl/axis_downsizer_scheduler.sv
// Round-robin burst scheduler feeding one downsizer from NCH wide AXI4-Stream sources; zero-latency mux,
// or +1 cycle via a 2-entry skid register when AXIS_DOWNSIZER_SCHEDULER_OUTREG_EN is defined.
module axis_downsizer_scheduler #(
  parameter int AXIS_TDATA_WIDTH = 128,
  parameter int NCH              = 4,
  parameter int CH_WIDTH         = 2
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [15:0]                     cfg_data,
  input  logic [NCH*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NCH-1:0]                  s_axis_tvalid,
  output logic [NCH-1:0]                  s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [CH_WIDTH-1:0]             sts_data
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                      state;
  logic [CH_WIDTH-1:0]         grant;
  logic [CH_WIDTH-1:0]         ptr;
  logic [CH_WIDTH-1:0]         sel;
  logic [CH_WIDTH-1:0]         idx;
  logic                        sel_vld;
  logic [15:0]                 len;
  logic [15:0]                 cnt;
  logic [AXIS_TDATA_WIDTH-1:0] mux_dat;
  logic                        mux_vld;
  logic                        mux_last;
  logic                        in_rdy;
  logic                        hs;

  // Scan backwards so the smallest offset after the pointer wins.
  always_comb begin
    sel     = ptr;
    sel_vld = 1'b0;
    idx     = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = CH_WIDTH'((int'(ptr) + i) % NCH);
      if (s_axis_tvalid[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  assign mux_dat  = s_axis_tdata[int'(grant)*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
  assign mux_vld  = (state == BURST) && s_axis_tvalid[grant];
  assign mux_last = (state == BURST) && (cnt == len);
  assign hs       = mux_vld && in_rdy;

  always_comb begin
    s_axis_tready = '0;
    if (state == BURST && in_rdy) s_axis_tready[grant] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= IDLE;
      grant    <= '0;
      sts_data <= '0;
      ptr      <= CH_WIDTH'(NCH - 1);
      len      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            grant    <= sel;
            sts_data <= sel;
            len      <= (cfg_data == 16'd0) ? 16'd0 : cfg_data - 16'd1;
            cnt      <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (hs) begin
            if (mux_last) begin
              ptr   <= grant;
              state <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_DOWNSIZER_SCHEDULER_OUTREG_EN
  logic [AXIS_TDATA_WIDTH-1:0] sk_dat [2];
  logic [1:0]                  sk_last;
  logic [1:0]                  sk_cnt;
  logic                        sk_wr;
  logic                        sk_rd;
  logic                        sk_pop;

  // Ready to the source is "not full", so no combinational path from m_axis_tready.
  assign in_rdy        = (sk_cnt != 2'd2);
  assign sk_pop        = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = (sk_cnt != 2'd0);
  assign m_axis_tdata  = sk_dat[sk_rd];
  assign m_axis_tlast  = m_axis_tvalid && sk_last[sk_rd];

  always_ff @(posedge aclk) begin
    if (hs) sk_dat[sk_wr] <= mux_dat;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sk_cnt  <= 2'd0;
      sk_wr   <= 1'b0;
      sk_rd   <= 1'b0;
      sk_last <= 2'b00;
    end else begin
      if (hs) begin
        sk_last[sk_wr] <= mux_last;
        sk_wr          <= ~sk_wr;
      end
      if (sk_pop) sk_rd <= ~sk_rd;
      case ({hs, sk_pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: sk_cnt <= sk_cnt;
      endcase
    end
  end
`else
  assign in_rdy        = m_axis_tready;
  assign m_axis_tdata  = mux_dat;
  assign m_axis_tvalid = mux_vld;
  assign m_axis_tlast  = mux_last;
`endif

endmodule

// File: doc/axis_downsizer_scheduler.md
Name: axis_downsizer_scheduler

Overview:
Round-robin scheduler that shares one downstream axis_downsizer between NCH wide AXI4-Stream sources, for example per-ADC-channel 128-bit streams.
Each grant moves a fixed-length burst of wide beats from one source, then moves to the next requesting source.
It emits tlast on the final beat of each burst and reports the granted channel index.
It sits directly upstream of the downsizer's slave port.

Parameters:
AXIS_TDATA_WIDTH, 128, width of each source and of the output tdata
NCH, 4, number of sources, 2..16
CH_WIDTH, 2, index width, equal to clog2(NCH) (minimum 1)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
cfg_data  in  16  burst length in wide beats; 0 is treated as 1
s_axis_tdata  in  NCH*AXIS_TDATA_WIDTH  concatenated source data; channel k occupies bits [k*W +: W]
s_axis_tvalid  in  NCH  per-source valid
s_axis_tready  out  NCH  per-source ready; one-hot or zero
m_axis_tdata  out  AXIS_TDATA_WIDTH  selected data, goes to the downsizer
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downsizer ready
m_axis_tlast  out  1  high on the last beat of a burst
sts_data  out  CH_WIDTH  granted or most-recently-granted channel index

Behaviour:
- Reset (aresetn low at a posedge):
  - state goes to IDLE, beat counter to 0, sts_data to 0.
  - Round-robin pointer goes to NCH-1, so channel 0 has first priority.
  - While in IDLE, s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0.
- State machine, two states:
  - IDLE:
    - Search channels cyclically from pointer+1, wrapping at NCH, for the first asserted s_axis_tvalid.
    - If one is found, on the next edge: grant register takes that index, sts_data takes it, the burst length register latches max(cfg_data,1)-1, counter clears, state goes to BURST.
    - If none is found, stay in IDLE.
    - Arbitration costs exactly 1 idle cycle between bursts.
  - BURST, with g = granted channel:
    - m_axis_tdata = source g's data and m_axis_tvalid = s_axis_tvalid[g], both combinational.
    - s_axis_tready[g] = m_axis_tready; all other ready bits are 0.
    - m_axis_tlast = (counter == latched length).
    - On each handshake (valid & ready): if tlast, the pointer takes g and state goes to IDLE; otherwise the counter increments.
    - No handshake: hold everything.
- No preemption:
  - If source g drops tvalid mid-burst, the grant is held until the burst completes, even if other sources are valid.
- cfg_data is sampled only at grant.
  - Changes during a burst affect only the next burst.
- Counter is 16 bits.
  - A burst of 65536 is not reachable: the maximum is 65535, from cfg_data = 65535.
- Data path adds no latency without the optional feature: zero-cycle pass-through.
- Reset during BURST:
  - The burst is abandoned with no tlast.
  - Any partial downstream frame is the downstream reset's responsibility; the scheduler and downsizer share aresetn.
- Only source g is ever acknowledged.
  - Data from non-granted sources is never consumed and never reordered.

Optional Feature:
Macro: AXIS_DOWNSIZER_SCHEDULER_OUTREG_EN.
- Defined:
  - A two-entry skid register sits between the mux and the m_axis port. It registers tdata, tvalid and tlast.
  - Latency is +1 cycle and sustained throughput is still 1 beat per cycle.
  - s_axis_tready[g] comes from the skid buffer's not-full flag instead of m_axis_tready, so there is no combinational ready path.
  - m_axis_tvalid resets to 0.
  - The IDLE gap between bursts remains 1 cycle on the input side.
- Undefined: pure combinational pass-through as described above.

Test Plan:
1. Single source: reset, cfg_data=4, only channel 2 valid with data 0x..01..04, tready=1.
   Required: exactly 4 output beats in 4 consecutive cycles after 1 idle cycle; tlast on beat 4 only; sts_data=2; s_axis_tready[2] high for 4 cycles.
2. All four sources valid continuously, cfg_data=2.
   Required: grant order 0,1,2,3,0; each burst is 2 beats plus 1 idle cycle; 15 cycles to complete 5 bursts.
3. Backpressure: cfg_data=3, m_axis_tready toggles 1,0,1,0.
   Required: beats are never duplicated or dropped; tlast is asserted on the 3rd handshake; the counter holds on stalled cycles.
4. Source gap: cfg_data=4, channel 1 granted, s_axis_tvalid[1] low for 3 cycles after beat 2 while channel 3 is valid.
   Required: grant stays 1, channel 3 tready stays 0, then beats 3-4 complete before channel 3 is granted.
5. Boundaries:
   - cfg_data=0 gives 1-beat bursts with tlast on every beat.
   - cfg_data changed from 2 to 5 mid-burst gives a current burst of 2 and a next burst of 5.
6. Reset after beat 1 of a 4-beat burst on channel 3.
   Required: outputs go to 0 the next cycle; after release, the first grant goes to channel 0 if valid.
   With AXIS_DOWNSIZER_SCHEDULER_OUTREG_EN defined, rerun scenarios 1-3 and require identical beat sequences shifted by 1 cycle.
